// File: rtl/nr_isqrt_refine.sv
// nr_isqrt_refine: multi-iteration Newton-Raphson inverse-sqrt refiner.
// Ports: clk, rst_n | in_valid/in_ready, x, y0, iters | out_valid/out_ready, y, sat, div0 | busy.
module nr_isqrt_refine #(
    parameter int INT_WIDTH   = 4,
    parameter int FRACT_WIDTH = 12,
    parameter int MAX_ITER    = 3,
    localparam int WORD       = INT_WIDTH + FRACT_WIDTH,
    localparam int ITER_W     = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD-1:0]   x,
    input  logic [WORD-1:0]   y0,
    input  logic [ITER_W-1:0] iters,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD-1:0]   y,
    output logic              sat,
    output logic              div0,
    output logic              busy
);

    localparam int PW = 2 * WORD;

    localparam logic [WORD-1:0] ONE_P5 =
        WORD'((1 << FRACT_WIDTH) | (1 << (FRACT_WIDTH - 1)));
    localparam logic [PW:0] HALF_LSB = (PW + 1)'(1 << (FRACT_WIDTH - 1));
    localparam logic [ITER_W-1:0] MAX_N = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQR,
        S_MULX,
        S_UPD,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [WORD-1:0]     r_y;
    logic [WORD-1:0]     r_xh;
    logic [WORD-1:0]     r_t;
    logic [ITER_W-1:0]   r_cnt;
    logic                r_sat;
    logic                r_div0;
    logic                r_out_valid;

    logic [ITER_W-1:0]   w_n;
    logic [WORD-1:0]     w_op_a;
    logic [WORD-1:0]     w_op_b;
    logic [PW-1:0]       w_prod;
    logic [PW:0]         w_sum;
    logic                w_ovf;
    logic [WORD-1:0]     w_rnd;
    logic                w_clamp;
    logic [WORD-1:0]     w_f;
    logic                w_unused_lsb;

    assign w_n = (iters > MAX_N) ? MAX_N : iters;

    // r_t holds t = y*y after SQR and a = x_half*t after MULX
    assign w_clamp = (r_t > ONE_P5);
    assign w_f     = w_clamp ? '0 : (ONE_P5 - r_t);

    // One shared multiplier; operands selected by state
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        unique case (r_state)
            S_SQR:   begin w_op_a = r_y;  w_op_b = r_y; end
            S_MULX:  begin w_op_a = r_xh; w_op_b = r_t; end
            S_UPD:   begin w_op_a = r_y;  w_op_b = w_f; end
            default: ;
        endcase
    end

    // Round to nearest, then saturate anything above the word range
    assign w_prod       = w_op_a * w_op_b;
    assign w_sum        = {1'b0, w_prod} + HALF_LSB;
    assign w_ovf        = |w_sum[PW:WORD+FRACT_WIDTH];
    assign w_rnd        = w_ovf ? '1 : w_sum[WORD+FRACT_WIDTH-1:FRACT_WIDTH];
    assign w_unused_lsb = &{1'b0, w_sum[FRACT_WIDTH-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_y         <= '0;
            r_xh        <= '0;
            r_t         <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_div0      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_xh   <= x >> 1;
                        r_cnt  <= w_n;
                        r_sat  <= 1'b0;
                        r_div0 <= 1'b0;
                        if (x == '0) begin
                            r_y     <= '1;
                            r_div0  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_n == '0) begin
                            r_y     <= y0;
                            r_state <= S_DONE;
                        end else begin
                            r_y     <= y0;
                            r_state <= S_SQR;
                        end
                    end
                end
                S_SQR: begin
                    r_t     <= w_rnd;
                    r_sat   <= r_sat | w_ovf;
                    r_state <= S_MULX;
                end
                S_MULX: begin
                    r_t     <= w_rnd;
                    r_sat   <= r_sat | w_ovf;
                    r_state <= S_UPD;
                end
                S_UPD: begin
                    r_y     <= w_rnd;
                    r_sat   <= r_sat | w_ovf | w_clamp;
                    r_cnt   <= r_cnt - 1'b1;
                    r_state <= (r_cnt == ITER_W'(1)) ? S_DONE : S_SQR;
                end
                S_DONE: begin
                    // First DONE cycle raises out_valid; handshake after that
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign sat       = r_sat;
    assign div0      = r_div0;

endmodule
